// File: rtl/text_row_ctrl.sv
// Byte-stream sequencer that turns UART bytes into character-buffer writes.
// Optional line scrolling is enabled with `define SCROLL_EN.
module text_row_ctrl #(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 4,
  parameter int          ADDR_W    = 6,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              refresh_req,
  input  logic              refresh_ack
);

  localparam int CELLS = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

`ifdef SCROLL_EN
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, SCROLL} state_t;
`else
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;
`endif

  state_t            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              refresh_req_q, refresh_req_d;
  logic              set_ref;

  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row_base;
  logic              is_prn, is_cr, is_lf, is_bs, is_ff;

`ifdef SCROLL_EN
  logic rd_act_q, rd_act_d;
  logic pend_q, pend_d;
`else
  logic unused_rd;
  assign unused_rd = ^rd_data;
`endif

  assign col      = cursor_q % COLS_A;
  assign row_base = cursor_q - col;

  assign is_prn = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign is_cr  = in_data == 8'h0D;
  assign is_lf  = in_data == 8'h0A;
  assign is_bs  = in_data == 8'h08;
  assign is_ff  = in_data == 8'h0C;

  always_comb begin
    state_d    = state_q;
    in_ready_d = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    cursor_d   = cursor_q;
    set_ref    = 1'b0;
`ifdef SCROLL_EN
    rd_act_d   = rd_act_q;
    pend_d     = pend_q;
`endif
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d = 1'b0;
          state_d    = WRITE;
          unique case (1'b1)
            is_prn: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cursor_q;
              wr_data_d = in_data;
              if (cursor_q == LAST) begin
`ifdef SCROLL_EN
                pend_d   = 1'b1;
`else
                cursor_d = '0;
`endif
              end else begin
                cursor_d = cursor_q + ONE;
              end
            end
            is_cr: cursor_d = row_base;
            is_lf: begin
              if (row_base == LAST_ROW) begin
`ifdef SCROLL_EN
                state_d   = SCROLL;
                rd_addr_d = COLS_A;
                rd_act_d  = 1'b1;
`else
                cursor_d  = '0;
`endif
              end else begin
                cursor_d = row_base + COLS_A;
              end
            end
            is_bs: begin
              if (col != '0) begin
                cursor_d  = cursor_q - ONE;
                wr_en_d   = 1'b1;
                wr_addr_d = cursor_q - ONE;
                wr_data_d = FILL_CHAR;
              end
            end
            is_ff: begin
              state_d   = CLEAR;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = FILL_CHAR;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
        set_ref    = wr_en_q;
`ifdef SCROLL_EN
        if (pend_q) begin
          state_d    = SCROLL;
          in_ready_d = 1'b0;
          set_ref    = 1'b0;
          pend_d     = 1'b0;
          rd_addr_d  = COLS_A;
          rd_act_d   = 1'b1;
        end
`endif
      end
      CLEAR: begin
        if (wr_addr_q == LAST) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
          cursor_d   = '0;
          set_ref    = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ONE;
        end
      end
`ifdef SCROLL_EN
      SCROLL: begin
        // copy lags the read address by one cycle, then the last row is filled
        if (rd_act_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_addr_q - COLS_A;
          wr_data_d = rd_data;
          if (rd_addr_q == LAST) begin
            rd_act_d  = 1'b0;
            rd_addr_d = '0;
          end else begin
            rd_addr_d = rd_addr_q + ONE;
          end
        end else if (wr_addr_q == LAST) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
          cursor_d   = LAST_ROW;
          set_ref    = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr_q + ONE;
          wr_data_d = FILL_CHAR;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    refresh_req_d = set_ref | (refresh_req_q & ~refresh_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      rd_addr_q     <= '0;
      cursor_q      <= '0;
      refresh_req_q <= 1'b0;
`ifdef SCROLL_EN
      rd_act_q      <= 1'b0;
      pend_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      rd_addr_q     <= rd_addr_d;
      cursor_q      <= cursor_d;
      refresh_req_q <= refresh_req_d;
`ifdef SCROLL_EN
      rd_act_q      <= rd_act_d;
      pend_q        <= pend_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign rd_addr     = rd_addr_q;
  assign cursor      = cursor_q;
  assign refresh_req = refresh_req_q;

endmodule

// File: tb/tb_text_row_ctrl.sv
// Directed-vector bench for text_row_ctrl with a simple buffer model.
// Scroll vectors are included when SCROLL_EN is defined.
module tb_text_row_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic [5:0] cursor;
  logic       refresh_req;
  logic       refresh_ack;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem [64];
  int   wr_cnt  = 0;
  int   rdy_bad = 0;
  int   seq_bad = 0;
  int   clr_idx = 0;
  logic clr_mon = 1'b0;

  text_row_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor(cursor),
    .refresh_req(refresh_req), .refresh_ack(refresh_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
  assign rd_data = mem[rd_addr];

  always @(posedge clk) begin
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (wr_en && in_ready) rdy_bad <= rdy_bad + 1;
    if (!clr_mon) clr_idx <= 0;
    else if (wr_en) begin
      if (wr_addr != clr_idx[5:0] || wr_data != 8'h20)
        seq_bad <= seq_bad + 1;
      clr_idx <= clr_idx + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rdy;
    int k = 0;
    while (!in_ready && k < 200) begin
      tick;
      k++;
    end
    if (!in_ready) chk("rdy_timeout", {31'd0, in_ready}, 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_rdy;
    in_valid = 1'b1;
    in_data  = b;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic send_idle(input logic [7:0] b);
    send(b);
    tick;
  endtask

  task automatic ack_ref;
    refresh_ack = 1'b1;
    tick;
    refresh_ack = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic lat(output int k);
    k = 1;
    while (!in_ready && k < 200) begin
      tick;
      k++;
    end
  endtask

  initial begin
    int k;
    int base;
    int bad;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    refresh_ack = 1'b0;
    tick;
    tick;
    chk("rst_ready", in_ready, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_refresh", refresh_req, 0);
    rst = 1'b0;
    tick;
    chk("ready_after_rst", in_ready, 1);

    send(8'h41);
    chk("A_wr_en", wr_en, 1);
    chk("A_wr_addr", wr_addr, 0);
    chk("A_wr_data", wr_data, 8'h41);
    chk("A_cursor", cursor, 1);
    chk("A_busy", in_ready, 0);
    tick;
    chk("A_ready", in_ready, 1);
    chk("A_wr_off", wr_en, 0);
    chk("A_data_hold", wr_data, 8'h41);
    chk("A_refresh", refresh_req, 1);
    tick;
    tick;
    chk("A_sticky", refresh_req, 1);
    ack_ref;
    chk("A_acked", refresh_req, 0);

    do_reset;
    for (int i = 0; i < 16; i++) send_idle(8'h30 + 8'(i));
    chk("row_cursor", cursor, 16);
    ack_ref;
    send_idle(8'h0D);
    chk("cr_cursor", cursor, 16);
    chk("cr_no_ref", refresh_req, 0);
    send(8'h5A);
    chk("Z_addr", wr_addr, 16);
    chk("Z_data", wr_data, 8'h5A);
    chk("Z_cursor", cursor, 17);
    tick;

    do_reset;
    for (int i = 0; i < 5; i++) send_idle(8'h61);
    send(8'h0A);
    chk("lf_no_wr", wr_en, 0);
    tick;
    chk("lf_cursor", cursor, 16);
    chk("lf_ready", in_ready, 1);

`ifndef SCROLL_EN
    do_reset;
    for (int i = 0; i < 3; i++) send_idle(8'h0A);
    chk("lf3_cursor", cursor, 48);
    send_idle(8'h0A);
    chk("lf_wrap", cursor, 0);
    do_reset;
    for (int i = 0; i < 3; i++) send_idle(8'h0A);
    for (int i = 0; i < 15; i++) send_idle(8'h71);
    chk("last_cursor", cursor, 63);
    send(8'h71);
    chk("last_addr", wr_addr, 63);
    tick;
    chk("last_wrap", cursor, 0);
`endif

    do_reset;
    send_idle(8'h41);
    send_idle(8'h0D);
    chk("bs0_cursor_pre", cursor, 0);
    send(8'h08);
    chk("bs0_no_wr", wr_en, 0);
    tick;
    chk("bs0_cursor", cursor, 0);
    chk("bs0_ref_kept", refresh_req, 1);
    chk("bs0_ready", in_ready, 1);
    ack_ref;
    send_idle(8'h0A);
    for (int i = 0; i < 4; i++) send_idle(8'h62);
    chk("bs_cursor_pre", cursor, 20);
    send(8'h08);
    chk("bs_wr_en", wr_en, 1);
    chk("bs_addr", wr_addr, 19);
    chk("bs_data", wr_data, 8'h20);
    chk("bs_cursor", cursor, 19);
    tick;

    ack_ref;
    send(8'h7F);
    chk("drop_no_wr", wr_en, 0);
    tick;
    chk("drop_ready", in_ready, 1);
    chk("drop_cursor", cursor, 19);
    chk("drop_no_ref", refresh_req, 0);
    send_idle(8'hC5);
    chk("drop_hi_cursor", cursor, 19);

    base = wr_cnt;
    clr_mon = 1'b1;
    send(8'h0C);
    lat(k);
    chk("ff_latency", k, 65);
    chk("ff_writes", wr_cnt - base, 64);
    chk("ff_sequence", seq_bad, 0);
    chk("ff_cursor", cursor, 0);
    chk("ff_refresh", refresh_req, 1);
    clr_mon = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] != 8'h20) bad++;
    chk("ff_mem", bad, 0);

    ack_ref;
    send_idle(8'h0A);
    send(8'h0C);
    for (int i = 0; i < 9; i++) tick;
    chk("rstclr_addr", wr_addr, 9);
    rst = 1'b1;
    tick;
    chk("rstclr_wr_off", wr_en, 0);
    chk("rstclr_cursor", cursor, 0);
    chk("rstclr_busy", in_ready, 0);
    rst = 1'b0;
    tick;
    chk("rstclr_ready", in_ready, 1);
    chk("rstclr_no_ref", refresh_req, 0);

    refresh_ack = 1'b1;
    send(8'h78);
    tick;
    chk("ackhold_set", refresh_req, 1);
    tick;
    chk("ackhold_clr", refresh_req, 0);
    send(8'h79);
    tick;
    chk("ackhold_set2", refresh_req, 1);
    tick;
    chk("ackhold_clr2", refresh_req, 0);
    refresh_ack = 1'b0;
    send(8'h79);
    tick;
    send(8'h7A);
    refresh_ack = 1'b1;
    tick;
    refresh_ack = 1'b0;
    chk("coincident", refresh_req, 1);
    tick;
    chk("coincident_hold", refresh_req, 1);
    ack_ref;

`ifdef SCROLL_EN
    do_reset;
    send(8'h0C);
    wait_rdy;
    ack_ref;
    for (int i = 0; i < 16; i++) send_idle(8'h61);
    for (int i = 0; i < 16; i++) send_idle(8'h62);
    for (int i = 0; i < 16; i++) send_idle(8'h63);
    for (int i = 0; i < 15; i++) send_idle(8'h64);
    chk("sc_cursor_pre", cursor, 63);
    base = wr_cnt;
    send(8'h0A);
    chk("sc_no_wr", wr_en, 0);
    chk("sc_rd_addr", rd_addr, 16);
    lat(k);
    chk("sc_latency", k, 66);
    chk("sc_writes", wr_cnt - base, 64);
    chk("sc_cursor", cursor, 48);
    tick;
    chk("sc_refresh", refresh_req, 1);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      logic [7:0] e;
      if (i < 16) e = 8'h62;
      else if (i < 32) e = 8'h63;
      else if (i < 47) e = 8'h64;
      else e = 8'h20;
      if (mem[i] != e) bad++;
    end
    chk("sc_mem", bad, 0);
`endif

    chk("wr_while_ready", rdy_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/text_row_ctrl.md
Name: text_row_ctrl

Overview:
- Sequencer between the UART byte receiver and the 4x16 character buffer read by the OLED row renderer.
- Accepts one byte at a time over a valid/ready handshake and decodes control codes (CR, LF, BS, FF).
- Drives single-port write commands into the character buffer, tracks the cursor, and flags the display engine to refresh after every change.

Parameters:
COLS, 16, characters per row
ROWS, 4, rows on screen
ADDR_W, 6, buffer address width; must satisfy ROWS*COLS <= 2**ADDR_W
FILL_CHAR, 8'h20, byte written by clear, backspace and scroll fill

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
in_valid  in  1  byte offered by UART receiver
in_data  in  8  offered byte
in_ready  out  1  controller can accept a byte this cycle
wr_en  out  1  buffer write strobe, one cell per cycle
wr_addr  out  ADDR_W  cell index = row*COLS+col
wr_data  out  8  byte to write
rd_addr  out  ADDR_W  buffer read address (SCROLL_EN only; tied 0 otherwise)
rd_data  in  8  buffer read data, valid 1 cycle after rd_addr
cursor  out  ADDR_W  current cursor cell
refresh_req  out  1  buffer changed since last ack
refresh_ack  in  1  display engine has taken a refresh

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port rst.
- Reset values: in_ready=0 while rst is high and 1 on the first cycle after. cursor=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, refresh_req=0, state=IDLE.
- Reset mid-operation: any clear or scroll sequence aborts immediately. No further writes are issued. Buffer contents are left as they are.
- All outputs are registered.
- States: IDLE, WRITE, CLEAR, SCROLL (SCROLL only with SCROLL_EN). in_ready=1 only in IDLE.
- A byte is accepted in cycle N when in_valid&&in_ready. It is latched and decoded at N+1.
- Printable byte (0x20..0x7E): WRITE.
  - wr_en=1 at N+1 with wr_addr=cursor, wr_data=byte.
  - cursor advances by 1.
  - At the last cell (ROWS*COLS-1), cursor wraps to 0 (scrolls with SCROLL_EN).
  - in_ready returns to 1 at N+2.
- 0x0D CR: cursor=row*COLS. No write. No refresh. in_ready=1 at N+2.
- 0x0A LF: cursor=(row+1)*COLS, col reset to 0. From the last row, cursor goes to 0 (scrolls with SCROLL_EN). No write.
- 0x08 BS:
  - If col>0: cursor decrements and FILL_CHAR is written to the new cursor at N+1.
  - If col==0: no-op, no refresh.
- 0x0C FF: CLEAR.
  - wr_en=1 for ROWS*COLS consecutive cycles N+1..N+64 (defaults), addresses 0..63 ascending, data FILL_CHAR.
  - cursor=0 at the end.
  - in_ready=1 at N+65.
- Any other byte (including 0x7F and 0x80..0xFF) is accepted and dropped, with in_ready=1 at N+2.
- refresh_req:
  - Sticky. Set in the cycle after the last write of any buffer-modifying command.
  - Cleared in the cycle after refresh_ack is sampled high while refresh_req=1.
  - Simultaneous set and ack: set wins, so refresh_req stays 1.
- Cursor arithmetic:
  - row = cursor / COLS, col = cursor % COLS.
  - Comparisons are done at ADDR_W width.
  - cursor never exceeds ROWS*COLS-1.
- wr_addr and wr_data hold their last values when wr_en=0.

Optional Feature:
SCROLL_EN
- Defined: an LF from the last row, or a printable write to the last cell (after it is written), enters SCROLL instead of wrapping.
- SCROLL read/copy phase:
  - rd_addr walks COLS..ROWS*COLS-1 on consecutive cycles.
  - Each rd_data is written one cycle later to rd_addr-COLS.
  - Default timing: reads N+1..N+48, writes N+2..N+49.
- SCROLL fill phase: the last row is filled with FILL_CHAR (writes N+50..N+65).
- After SCROLL: cursor=(ROWS-1)*COLS, in_ready=1 at N+66, then refresh_req is set.
- Not defined: no SCROLL state; rd_addr is held at 0 and rd_data is ignored; wrap-to-0 as above.

Test Plan:
- Reset, then send 'A'(0x41) at cycle N -> wr_en=1, wr_addr=0, wr_data=0x41 at N+1; cursor=1; in_ready=1 at N+2; refresh_req=1 until refresh_ack.
- Send 16 printable bytes, then CR, then 'Z' -> 'Z' written to addr 16 (CR at col 0 of row 1 is a no-op); LF from cursor=5 -> cursor=16; LF on row 3 (no SCROLL_EN) -> cursor=0.
- Cursor=0, send BS -> no write, refresh_req unchanged; cursor=20, send BS -> write 0x20 at addr 19, cursor=19.
- Send FF -> exactly 64 wr_en cycles, addresses 0..63, data 0x20, in_ready held 0 throughout; assert rst at cycle 10 of clear -> wr_en=0 the next cycle, cursor=0.
- Hold refresh_ack=1 continuously while streaming bytes -> refresh_req pulses set on each write cycle and never sticks; coincident set and ack keeps refresh_req=1.
- SCROLL_EN: preload rows with 'a','b','c','d', send LF on row 3 -> rows become b,c,d,spaces; cursor=48; total of 64 write cycles.
